// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter with multi-cycle grant hold, explicit release and hold-timeout watchdog
module rr_hold_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 8,
    localparam int IDW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
    localparam int CW  = $clog2(MAX_HOLD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] release_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDW-1:0]       gnt_id_o,
    output logic                 gnt_valid_o,
    output logic                 timeout_o
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [IDW:0]  NP   = (IDW + 1)'(NUM_PORTS);
    localparam logic [CW-1:0] MAXC = CW'(MAX_HOLD);

    state_t               r_state, w_state_nxt;
    logic [IDW-1:0]       r_ptr, w_ptr_nxt, r_id, w_id_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [NUM_PORTS-1:0] r_gnt, w_gnt_nxt;
    logic                 r_valid, w_valid_nxt, r_to, w_to_nxt;
    logic [2*NUM_PORTS-1:0] w_req2;
    logic [NUM_PORTS-1:0] w_rot;
    logic [IDW-1:0]       w_off, w_win;
    logic [IDW:0]         w_sum, w_inc;
    logic                 w_found, w_rel, w_drop, w_full, w_end;

    // Requests rotated so that bit 0 is the port at the fairness pointer
    assign w_req2  = {req_i, req_i};
    assign w_rot   = w_req2[r_ptr +: NUM_PORTS];
    assign w_found = |w_rot;

    // Lowest set bit of the rotated vector is the winner's distance from the pointer
    always_comb begin
        w_off = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--)
            if (w_rot[k]) w_off = IDW'(k);
    end

    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win = (w_sum >= NP) ? IDW'(w_sum - NP) : IDW'(w_sum);
    assign w_inc = {1'b0, r_id} + (IDW + 1)'(1);

    assign w_rel  = release_i[r_id];
    assign w_drop = ~req_i[r_id];
    assign w_full = (r_cnt == MAXC);
    assign w_end  = w_rel | w_drop | w_full;

    // Next state: arbitrate when idle, drop back to idle when the grant ends
    assign w_state_nxt = (r_state == S_IDLE) ? (w_found ? S_GRANT : S_IDLE)
                                             : (w_end ? S_IDLE : S_GRANT);

    // Next registered outputs, pointer and hold counter
    always_comb begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_to_nxt    = 1'b0;
        w_id_nxt    = r_id;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = '0;
        if (r_state == S_IDLE) begin
            if (w_found) begin
                w_gnt_nxt   = NUM_PORTS'(1) << w_win;
                w_valid_nxt = 1'b1;
                w_id_nxt    = w_win;
                w_cnt_nxt   = CW'(1);
            end
        end else if (w_end) begin
            w_ptr_nxt = (w_inc == NP) ? '0 : w_inc[IDW-1:0];
            w_to_nxt  = w_full & ~w_rel & ~w_drop;
        end else begin
            w_gnt_nxt   = r_gnt;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = w_full ? r_cnt : r_cnt + CW'(1);
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_id    <= w_id_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
            r_to    <= w_to_nxt;
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_id_o    = r_id;
    assign gnt_valid_o = r_valid;
    assign timeout_o   = r_to;
endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Parametrised round-robin arbiter with multi-cycle grant hold, explicit release, and a hold-timeout watchdog. Shares one resource (bus, memory port, shared pipeline stage) among `NUM_PORTS` requesters. The fairness pointer advances past the last holder only when a grant ends, never free-running. Grants are registered and one-hot, with a binary grant index alongside.

## Interface
- `NUM_PORTS`, 4: number of requesters; legal range 2..32, not restricted to powers of two.
- `MAX_HOLD`, 8: maximum consecutive cycles one grant may be held; legal range 1..255.
- Derived (localparam) `IDW` = max(1, $clog2(NUM_PORTS)); `CW` = $clog2(MAX_HOLD+1).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_i`  in  NUM_PORTS  request per port; level, held while the port wants or owns the resource.
- `release_i`  in  NUM_PORTS  end-of-transaction strobe; only the bit of the current holder is honoured.
- `gnt_o`  out  NUM_PORTS  registered one-hot grant; all-zero when idle.
- `gnt_id_o`  out  IDW  binary index of current holder; holds last holder's value when idle.
- `gnt_valid_o`  out  1  high whenever `gnt_o` is non-zero.
- `timeout_o`  out  1  one-cycle pulse when a grant is force-released by the watchdog.

## Operation
- Reset values: state IDLE, pointer `ptr`=0, `gnt_o`=0, `gnt_id_o`=0, `gnt_valid_o`=0, `timeout_o`=0, hold counter=0.
- Two-state FSM: IDLE, GRANT.
- **IDLE**
  - Search `req_i` starting at index `ptr`, ascending, wrapping modulo NUM_PORTS.
  - First set bit k wins: next cycle `gnt_o`=1<<k, `gnt_id_o`=k, `gnt_valid_o`=1, counter=1, state GRANT.
  - If no request is set, stay IDLE with outputs zero.
- **GRANT** (holder h): the grant ends at the cycle where any of the following is true:
  - (a) `release_i[h]`=1;
  - (b) `req_i[h]`=0 (requester abandoned);
  - (c) counter==MAX_HOLD.
- On grant end:
  - Next cycle state IDLE, `gnt_o`=0, `gnt_valid_o`=0, `ptr`=(h+1) mod NUM_PORTS.
  - If (c) holds and neither (a) nor (b) does, `timeout_o`=1 for that one cycle.
- Otherwise the counter increments (saturates at MAX_HOLD; never wraps).
- `release_i` bits of non-holders, and `release_i` while IDLE, are ignored.
- Requests from non-holders during GRANT are ignored; they wait for the next IDLE arbitration and are never lost as long as `req_i` stays high.
- The pointer never changes in IDLE, so a port passed over while idle keeps its relative priority.
- Wrap: with `ptr`=NUM_PORTS-1, search order is NUM_PORTS-1, 0, 1, …; modulo is correct for non-power-of-two NUM_PORTS.
- Fairness bound: a continuously requesting port is granted within (NUM_PORTS-1)×(MAX_HOLD+1)+1 cycles of its request being sampled in IDLE.

## Timing
- Arbitration latency: request sampled in IDLE at cycle T → `gnt_o` high at T+1.
- Grant duration: from 1 to MAX_HOLD cycles inclusive.
  - Release at the first grant cycle gives exactly a 1-cycle grant.
- Exactly one idle bubble follows every grant: end condition at T → `gnt_o`=0 at T+1 → the next grant (if any) is at T+2.
- `timeout_o` is asserted in the same cycle that `gnt_o` first reads zero.
- Asynchronous reset mid-grant:
  - All outputs clear immediately, without waiting for a clock edge.
  - `ptr` returns to 0.
  - After deassertion, the first rising edge performs IDLE arbitration.
- Simultaneous release and timeout: counted as a normal release, no `timeout_o`.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then `req_i`=4'b1010 held with `release_i`=0 (NUM_PORTS=4, MAX_HOLD=8):
  - Grant to port 1 for 8 cycles, then `timeout_o` pulse and 1 idle cycle.
  - Grant to port 3 for 8 cycles, then timeout, then back to port 1.
  - `gnt_id_o` follows 1, 3, 1.
- All four requesting, each holder pulses `release_i` on its 2nd grant cycle:
  - Grant order 0, 1, 2, 3, 0; each grant is 2 cycles with a 1-cycle gap; `timeout_o` never asserts.
- Port 2 holding, port 2 drops `req_i` at grant cycle 3 while ports 0 and 3 request:
  - `gnt_o`=0 next cycle, no timeout; the next grant goes to port 3, not port 0.
- `release_i`=4'b0001 pulsed while port 2 holds:
  - Ignored; grant continues.
  - Then `release_i[2]` plus timeout fire on the same cycle: grant ends with `timeout_o`=0.
- Reset asserted asynchronously mid-grant, between clock edges:
  - `gnt_o`, `gnt_valid_o` and `timeout_o` go 0 immediately.
  - After release, `req_i`=4'b1000 → grant to port 3 one cycle later; `ptr` was back at 0.
- NUM_PORTS=5, MAX_HOLD=1, all requesting:
  - Single-cycle grants cycle 0, 1, 2, 3, 4, 0, each with a `timeout_o` pulse.
  - Confirms non-power-of-two wrap.
